// File: rtl/vlane_pkg.sv
// Shared definitions for the vector lane datapath stages: default widths and
// saturation bounds.
package vlane_pkg;

    localparam int IN_WIDTH_DEF  = 16;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int OUT_WIDTH_DEF = 32;

    // Bounds are returned at 64 bits so any accumulator up to 64 bits compares directly.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/vmac_sat.sv
// Combinational signed clamp from ACC_WIDTH down to OUT_WIDTH, flagging when
// the value had to be clamped.
module vmac_sat
    import vlane_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] i_sum,
    output logic        [OUT_WIDTH-1:0] o_data,
    output logic                        o_sat
);

    localparam logic signed [63:0] MAX_V = sat_max(OUT_WIDTH);
    localparam logic signed [63:0] MIN_V = sat_min(OUT_WIDTH);

    logic signed [63:0] sum_ext;

    always_comb begin
        sum_ext = 64'(i_sum);
        o_data  = i_sum[OUT_WIDTH-1:0];
        o_sat   = 1'b0;
        if (sum_ext > MAX_V) begin
            o_data = MAX_V[OUT_WIDTH-1:0];
            o_sat  = 1'b1;
        end else if (sum_ext < MIN_V) begin
            o_data = MIN_V[OUT_WIDTH-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/vmac_accum_stage.sv
// Two-stage signed multiply-accumulate: S1 registers the product, S2 folds it
// into the accumulator and emits the saturated total on the last beat.
module vmac_accum_stage
    import vlane_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic signed [IN_WIDTH-1:0] i_a,
    input  logic signed [IN_WIDTH-1:0] i_b,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic       [OUT_WIDTH-1:0] o_data,
    output logic                       o_sat
);

    logic signed [2*IN_WIDTH-1:0] prod_d, prod_q;
    logic                         s1_valid_d, s1_valid_q;
    logic                         s1_last_d, s1_last_q;
    logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic        [OUT_WIDTH-1:0]  data_d, data_q;
    logic                         sat_d, sat_q;
    logic                         out_valid_d, out_valid_q;
    logic        [OUT_WIDTH-1:0]  clamp_data;
    logic                         clamp_sat;
    logic                         advance;

    vmac_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .i_sum  (sum),
        .o_data (clamp_data),
        .o_sat  (clamp_sat)
    );

    always_comb begin
        advance     = !out_valid_q || i_ready;
        sum         = acc_q + ACC_WIDTH'(prod_q);
        prod_d      = prod_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        data_d      = data_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        if (i_clear) begin
            prod_d      = '0;
            s1_valid_d  = 1'b0;
            s1_last_d   = 1'b0;
            acc_d       = '0;
            data_d      = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end else if (advance) begin
            prod_d      = i_a * i_b;
            s1_valid_d  = i_valid;
            s1_last_d   = i_last;
            out_valid_d = 1'b0;
            // Last beat restarts acc at zero so the next stream needs no bubble.
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_d       = '0;
                    data_d      = clamp_data;
                    sat_d       = clamp_sat;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            data_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_ready = advance;
    assign o_valid = out_valid_q;
    assign o_data  = data_q;
    assign o_sat   = sat_q;

endmodule
